tcm_dport_arbiter: RTL and testbench

// - Shares the single tcm_mem data port between two masters: m0 = riscv_core data port, m1 = loader/debug master.
// - Sits between u_dut mem_d_* and u_mem mem_d_*. Grants one request per cycle and routes in-order acks/data back to the issuer.
// - Replaces testbench backdoor u_mem.write() preload and marker polling with a bus master path on the real data port.

---
 rtl/tcm_dport_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_tcm_dport_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tcm_dport_arbiter.sv
// Two-master arbiter for the tcm_mem data port (m0 = core, m1 = loader/debug), with in-order ack routing.
// Define TCM_ARB_RR_EN for round-robin arbitration; otherwise m0 wins every contention.
module tcm_dport_arbiter #(
    parameter int OUTSTANDING = 4,
    parameter int PTR_W       = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_wr_i,
    input  logic        m0_rd_i,
    input  logic [3:0]  m0_wr_i,
    input  logic        m0_cacheable_i,
    input  logic        m0_invalidate_i,
    input  logic        m0_writeback_i,
    input  logic        m0_flush_i,
    input  logic [10:0] m0_req_tag_i,
    output logic        m0_accept_o,
    output logic        m0_ack_o,
    output logic        m0_error_o,
    output logic [31:0] m0_data_rd_o,
    output logic [10:0] m0_resp_tag_o,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_wr_i,
    input  logic        m1_rd_i,
    input  logic [3:0]  m1_wr_i,
    input  logic [10:0] m1_req_tag_i,
    output logic        m1_accept_o,
    output logic        m1_ack_o,
    output logic        m1_error_o,
    output logic [31:0] m1_data_rd_o,
    output logic [10:0] m1_resp_tag_o,
    output logic [31:0] mem_d_addr_o,
    output logic [31:0] mem_d_data_wr_o,
    output logic        mem_d_rd_o,
    output logic [3:0]  mem_d_wr_o,
    output logic        mem_d_cacheable_o,
    output logic [10:0] mem_d_req_tag_o,
    output logic        mem_d_invalidate_o,
    output logic        mem_d_writeback_o,
    output logic        mem_d_flush_o,
    input  logic        mem_d_accept_i,
    input  logic        mem_d_ack_i,
    input  logic        mem_d_error_i,
    input  logic [31:0] mem_d_data_rd_i,
    input  logic [10:0] mem_d_resp_tag_i,
    output logic        overflow_o
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t             state_reg, state_next;
    logic               hold_id_reg, hold_id_next;
    logic               m0_req, m1_req;
    logic               idle_winner;
    logic               gnt_valid, gnt_id;
    logic               present, sel_m1, m0_fwd, transfer;
    logic [PTR_W:0]     count_reg;
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic               src_reg [OUTSTANDING];
    logic               fifo_empty, fifo_full, pop, head_id;
    logic               overflow_reg;
`ifdef TCM_ARB_RR_EN
    logic               last_grant_reg;
`endif

    assign m0_req = m0_rd_i | (|m0_wr_i) | m0_invalidate_i | m0_writeback_i | m0_flush_i;
    assign m1_req = m1_rd_i | (|m1_wr_i);

    always_comb begin
        idle_winner = 1'b0;
        if (m0_req && m1_req) begin
`ifdef TCM_ARB_RR_EN
            idle_winner = ~last_grant_reg;
`else
            idle_winner = 1'b0;
`endif
        end else if (m1_req) begin
            idle_winner = 1'b1;
        end
    end

    assign fifo_empty = (count_reg == '0);
    assign pop        = mem_d_ack_i & ~fifo_empty & ~rst_i;
    // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
    assign fifo_full  = (count_reg == (PTR_W+1)'(OUTSTANDING)) & ~pop;
    assign head_id    = src_reg[rd_ptr_reg];

    always_comb begin
        state_next   = state_reg;
        hold_id_next = hold_id_reg;
        gnt_valid    = 1'b0;
        gnt_id       = 1'b0;
        case (state_reg)
            IDLE: begin
                gnt_valid = m0_req | m1_req;
                gnt_id    = idle_winner;
                if (gnt_valid && !fifo_full && !mem_d_accept_i) begin
                    state_next   = HOLD;
                    hold_id_next = idle_winner;
                end
            end
            HOLD: begin
                gnt_id    = hold_id_reg;
                gnt_valid = hold_id_reg ? m1_req : m0_req;
                if (!gnt_valid || (!fifo_full && mem_d_accept_i))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign present  = gnt_valid & ~fifo_full & ~rst_i;
    assign sel_m1   = gnt_valid & gnt_id;
    assign m0_fwd   = present & ~gnt_id;
    assign transfer = present & mem_d_accept_i;

    assign mem_d_addr_o       = sel_m1 ? m1_addr_i    : m0_addr_i;
    assign mem_d_data_wr_o    = sel_m1 ? m1_data_wr_i : m0_data_wr_i;
    assign mem_d_req_tag_o    = sel_m1 ? m1_req_tag_i : m0_req_tag_i;
    assign mem_d_rd_o         = present & (sel_m1 ? m1_rd_i : m0_rd_i);
    assign mem_d_wr_o         = {4{present}} & (sel_m1 ? m1_wr_i : m0_wr_i);
    // Cache maintenance belongs to the core only; m1 never drives these.
    assign mem_d_cacheable_o  = m0_fwd & m0_cacheable_i;
    assign mem_d_invalidate_o = m0_fwd & m0_invalidate_i;
    assign mem_d_writeback_o  = m0_fwd & m0_writeback_i;
    assign mem_d_flush_o      = m0_fwd & m0_flush_i;

    assign m0_accept_o   = transfer & ~gnt_id;
    assign m1_accept_o   = transfer & gnt_id;
    assign m0_ack_o      = pop & ~head_id;
    assign m1_ack_o      = pop & head_id;
    assign m0_error_o    = mem_d_error_i & m0_ack_o;
    assign m1_error_o    = mem_d_error_i & m1_ack_o;
    assign m0_data_rd_o  = mem_d_data_rd_i;
    assign m1_data_rd_o  = mem_d_data_rd_i;
    assign m0_resp_tag_o = mem_d_resp_tag_i;
    assign m1_resp_tag_o = mem_d_resp_tag_i;
    assign overflow_o    = overflow_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            hold_id_reg  <= 1'b0;
            overflow_reg <= 1'b0;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            hold_id_reg <= hold_id_next;
            if (mem_d_ack_i && fifo_empty)
                overflow_reg <= 1'b1;
            if (transfer)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({transfer, pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < OUTSTANDING; gi++) begin : g_src
            always_ff @(posedge clk_i) begin
                if (rst_i)
                    src_reg[gi] <= 1'b0;
                else if (transfer && (wr_ptr_reg == PTR_W'(gi)))
                    src_reg[gi] <= gnt_id;
            end
        end
    endgenerate

`ifdef TCM_ARB_RR_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)
            last_grant_reg <= 1'b1;
        else if (transfer)
            last_grant_reg <= gnt_id;
    end
`endif

endmodule

// File: tb/tb_tcm_dport_arbiter.sv
// Directed table-driven bench for tcm_dport_arbiter; expectations follow TCM_ARB_RR_EN when defined.
module tb_tcm_dport_arbiter;

`ifdef TCM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [31:0] M0_ADDR = 32'h0000_1000;
    localparam logic [31:0] M1_ADDR = 32'h8000_9030;
    localparam logic [31:0] M0_DATA = 32'h1111_2222;
    localparam logic [31:0] M1_DATA = 32'hDEAD_BEEF;
    localparam logic [10:0] T0      = 11'h0A5;
    localparam logic [10:0] T1      = 11'h35A;

    logic        clk, rst;
    logic [31:0] m0_addr, m0_data_wr, m1_addr, m1_data_wr;
    logic        m0_rd, m1_rd, m0_cacheable, m0_invalidate, m0_writeback, m0_flush;
    logic [3:0]  m0_wr, m1_wr;
    logic [10:0] m0_req_tag, m1_req_tag;
    logic        m0_accept, m0_ack, m0_error, m1_accept, m1_ack, m1_error;
    logic [31:0] m0_data_rd, m1_data_rd;
    logic [10:0] m0_resp_tag, m1_resp_tag;
    logic [31:0] mem_addr, mem_data_wr;
    logic        mem_rd, mem_cacheable, mem_invalidate, mem_writeback, mem_flush;
    logic [3:0]  mem_wr;
    logic [10:0] mem_req_tag;
    logic        mem_accept, mem_ack, mem_error;
    logic [31:0] mem_data_rd;
    logic [10:0] mem_resp_tag;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    tcm_dport_arbiter #(.OUTSTANDING(4), .PTR_W(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_addr_i(m0_addr), .m0_data_wr_i(m0_data_wr), .m0_rd_i(m0_rd), .m0_wr_i(m0_wr),
        .m0_cacheable_i(m0_cacheable), .m0_invalidate_i(m0_invalidate),
        .m0_writeback_i(m0_writeback), .m0_flush_i(m0_flush), .m0_req_tag_i(m0_req_tag),
        .m0_accept_o(m0_accept), .m0_ack_o(m0_ack), .m0_error_o(m0_error),
        .m0_data_rd_o(m0_data_rd), .m0_resp_tag_o(m0_resp_tag),
        .m1_addr_i(m1_addr), .m1_data_wr_i(m1_data_wr), .m1_rd_i(m1_rd), .m1_wr_i(m1_wr),
        .m1_req_tag_i(m1_req_tag),
        .m1_accept_o(m1_accept), .m1_ack_o(m1_ack), .m1_error_o(m1_error),
        .m1_data_rd_o(m1_data_rd), .m1_resp_tag_o(m1_resp_tag),
        .mem_d_addr_o(mem_addr), .mem_d_data_wr_o(mem_data_wr), .mem_d_rd_o(mem_rd),
        .mem_d_wr_o(mem_wr), .mem_d_cacheable_o(mem_cacheable), .mem_d_req_tag_o(mem_req_tag),
        .mem_d_invalidate_o(mem_invalidate), .mem_d_writeback_o(mem_writeback),
        .mem_d_flush_o(mem_flush),
        .mem_d_accept_i(mem_accept), .mem_d_ack_i(mem_ack), .mem_d_error_i(mem_error),
        .mem_d_data_rd_i(mem_data_rd), .mem_d_resp_tag_i(mem_resp_tag),
        .overflow_o(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, actual=running required=done");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        rst, m0r;
        logic [3:0]  m0w;
        logic        m1r;
        logic [3:0]  m1w;
        logic        acc, ack, err;
        logic [10:0] rtag;
        logic        ea0, ea1, ek0, ek1, erd;
        logic [3:0]  ewr;
        logic        esel, ee0, ee1, eovf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst_v, m0r, input logic [3:0] m0w,
                                input logic m1r, input logic [3:0] m1w,
                                input logic acc, ack, err, input logic [10:0] rtag,
                                input logic ea0, ea1, ek0, ek1, erd, input logic [3:0] ewr,
                                input logic esel, ee0, ee1, eovf);
        vec_t v;
        v.rst = rst_v; v.m0r = m0r; v.m0w = m0w; v.m1r = m1r; v.m1w = m1w;
        v.acc = acc; v.ack = ack; v.err = err; v.rtag = rtag;
        v.ea0 = ea0; v.ea1 = ea1; v.ek0 = ek0; v.ek1 = ek1; v.erd = erd; v.ewr = ewr;
        v.esel = esel; v.ee0 = ee0; v.ee1 = ee1; v.eovf = eovf;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        rst = 1'b0; m0_rd = 1'b0; m0_wr = 4'h0; m1_rd = 1'b0; m1_wr = 4'h0;
        m0_cacheable = 1'b0; m0_invalidate = 1'b0; m0_writeback = 1'b0; m0_flush = 1'b0;
        mem_accept = 1'b0; mem_ack = 1'b0; mem_error = 1'b0;
        mem_resp_tag = 11'h0; mem_data_rd = 32'h0;
    endtask

    initial begin
        logic [63:0] act, exp;
        m0_addr = M0_ADDR; m1_addr = M1_ADDR; m0_data_wr = M0_DATA; m1_data_wr = M1_DATA;
        m0_req_tag = T0; m1_req_tag = T1;
        drive_idle();
        rst = 1'b1;

        // rst m0r m0w m1r m1w acc ack err rtag | a0 a1 k0 k1 rd wr sel e0 e1 ovf
        add(1,0,0,0,0,  0,0,0,0,  0,0,0,0,0,0,0,0,0,0);             // r0 reset
        add(0,0,0,0,4'hF,1,0,0,0, 0,1,0,0,0,4'hF,1,0,0,0);          // r1 m1 write
        add(0,0,0,0,0,  0,1,0,T1, 0,0,0,1,0,0,0,0,0,0);             // r2 ack -> m1
        add(0,1,0,1,0,  1,0,0,0,  1,0,0,0,1,0,0,0,0,0);             // r3 contention
        add(0,1,0,1,0,  1,1,0,T0, !RR,RR,1,0,1,0,RR,0,0,0);         // r4
        add(0,1,0,1,0,  1,1,0,RR?T1:T0, 1,0,!RR,RR,1,0,0,0,0,0);    // r5
        add(0,0,0,1,0,  1,1,0,T0, 0,1,1,0,1,0,1,0,0,0);             // r6 m0 drops
        add(0,0,0,0,0,  0,1,0,T1, 0,0,0,1,0,0,0,0,0,0);             // r7
        add(0,1,0,0,0,  0,0,0,0,  0,0,0,0,1,0,0,0,0,0);             // r8 stall -> HOLD m0
        add(0,1,0,1,0,  0,0,0,0,  0,0,0,0,1,0,0,0,0,0);             // r9
        add(0,1,0,1,0,  0,0,0,0,  0,0,0,0,1,0,0,0,0,0);             // r10
        add(0,1,0,1,0,  1,0,0,0,  1,0,0,0,1,0,0,0,0,0);             // r11 m0 accepted
        add(0,0,0,1,0,  1,0,0,0,  0,1,0,0,1,0,1,0,0,0);             // r12 m1 next
        add(0,0,0,0,0,  0,1,0,T0, 0,0,1,0,0,0,0,0,0,0);             // r13
        add(0,0,0,0,0,  0,1,1,T1, 0,0,0,1,0,0,0,0,1,0);             // r14 error to m1
        add(0,0,0,1,0,  0,0,0,0,  0,0,0,0,1,0,1,0,0,0);             // r15 HOLD m1
        add(0,1,0,1,0,  0,0,0,0,  0,0,0,0,1,0,1,0,0,0);             // r16 lock beats priority
        add(0,1,0,1,0,  1,0,0,0,  0,1,0,0,1,0,1,0,0,0);             // r17
        add(0,1,0,0,0,  1,0,0,0,  1,0,0,0,1,0,0,0,0,0);             // r18
        add(0,0,0,0,0,  0,1,0,T1, 0,0,0,1,0,0,0,0,0,0);             // r19
        add(0,0,0,0,0,  0,1,0,T0, 0,0,1,0,0,0,0,0,0,0);             // r20
        add(0,0,0,1,0,  0,0,0,0,  0,0,0,0,1,0,1,0,0,0);             // r21 HOLD m1
        add(0,1,0,0,0,  1,0,0,0,  0,0,0,0,0,0,0,0,0,0);             // r22 m1 drops: no transfer
        add(0,1,0,0,0,  1,0,0,0,  1,0,0,0,1,0,0,0,0,0);             // r23
        add(0,0,0,0,0,  0,1,0,T0, 0,0,1,0,0,0,0,0,0,0);             // r24
        add(0,1,0,0,0,  1,0,0,0,  1,0,0,0,1,0,0,0,0,0);             // r25 fill
        add(0,1,0,0,0,  1,0,0,0,  1,0,0,0,1,0,0,0,0,0);             // r26
        add(0,1,0,0,0,  1,0,0,0,  1,0,0,0,1,0,0,0,0,0);             // r27
        add(0,1,0,0,0,  1,0,0,0,  1,0,0,0,1,0,0,0,0,0);             // r28 full
        add(0,1,0,0,0,  1,0,0,0,  0,0,0,0,0,0,0,0,0,0);             // r29 stalled
        add(0,1,0,0,0,  1,1,0,T0, 1,0,1,0,1,0,0,0,0,0);             // r30 push+pop at full
        add(0,0,0,0,0,  0,1,0,T0, 0,0,1,0,0,0,0,0,0,0);             // r31 drain
        add(0,0,0,0,0,  0,1,0,T0, 0,0,1,0,0,0,0,0,0,0);             // r32
        add(0,0,0,0,0,  0,1,0,T0, 0,0,1,0,0,0,0,0,0,0);             // r33
        add(0,0,0,0,0,  0,1,0,T0, 0,0,1,0,0,0,0,0,0,0);             // r34
        add(0,0,0,0,0,  0,1,1,0,  0,0,0,0,0,0,0,0,0,0);             // r35 ack on empty
        add(0,1,0,0,0,  1,0,0,0,  1,0,0,0,1,0,0,0,0,1);             // r36 sticky overflow
        add(1,1,0,0,0,  1,1,0,T0, 0,0,0,0,0,0,0,0,0,1);             // r37 reset mid-traffic
        add(0,0,0,0,0,  0,0,0,0,  0,0,0,0,0,0,0,0,0,0);             // r38
        add(0,0,0,0,4'hF,1,0,0,0, 0,1,0,0,0,4'hF,1,0,0,0);          // r39 write after reset

        repeat (2) @(posedge clk);
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            drive_idle();
            rst = vecs[i].rst; m0_rd = vecs[i].m0r; m0_wr = vecs[i].m0w;
            m1_rd = vecs[i].m1r; m1_wr = vecs[i].m1w;
            mem_accept = vecs[i].acc; mem_ack = vecs[i].ack; mem_error = vecs[i].err;
            mem_resp_tag = vecs[i].rtag;
            mem_data_rd = {21'h0, vecs[i].rtag} ^ 32'h5A5A_0000;
            @(negedge clk);
            act = {19'h0, m0_accept, m1_accept, m0_ack, m1_ack, mem_rd, mem_wr,
                   m0_error, m1_error, overflow, mem_addr};
            exp = {19'h0, vecs[i].ea0, vecs[i].ea1, vecs[i].ek0, vecs[i].ek1, vecs[i].erd,
                   vecs[i].ewr, vecs[i].ee0, vecs[i].ee1, vecs[i].eovf,
                   (vecs[i].esel ? M1_ADDR : M0_ADDR)};
            chk($sformatf("row%0d", i), act, exp);
            if (vecs[i].ek0)
                chk($sformatf("row%0d m0 tag/data", i), {21'h0, m0_resp_tag, m0_data_rd},
                    {21'h0, vecs[i].rtag, {21'h0, vecs[i].rtag} ^ 32'h5A5A_0000});
            if (vecs[i].ek1)
                chk($sformatf("row%0d m1 tag/data", i), {21'h0, m1_resp_tag, m1_data_rd},
                    {21'h0, vecs[i].rtag, {21'h0, vecs[i].rtag} ^ 32'h5A5A_0000});
            if (vecs[i].ewr != 4'h0)
                chk($sformatf("row%0d wdata/tag", i), {21'h0, mem_req_tag, mem_data_wr},
                    {21'h0, (vecs[i].esel ? T1 : T0), (vecs[i].esel ? M1_DATA : M0_DATA)});
            $display("row %0d: a0=%0b a1=%0b k0=%0b k1=%0b rd=%0b wr=%h ovf=%0b",
                     i, m0_accept, m1_accept, m0_ack, m1_ack, mem_rd, mem_wr, overflow);
        end

        // Cache ops are forwarded only while m0 actually owns the port.
        @(posedge clk); #1; drive_idle();
        mem_ack = 1'b1; mem_resp_tag = T1;
        @(negedge clk);
        chk("drain m1 ack", {63'h0, m1_ack}, 64'h1);
        $display("seq drain: m1_ack=%0b", m1_ack);

        @(posedge clk); #1; drive_idle();
        m1_rd = 1'b1;
        @(negedge clk);
        chk("hold m1 rd", {63'h0, mem_rd}, 64'h1);
        $display("seq hold: rd=%0b", mem_rd);

        @(posedge clk); #1; drive_idle();
        m1_rd = 1'b1; m0_flush = 1'b1;
        @(negedge clk);
        chk("flush blocked in m1 hold", {31'h0, mem_flush, mem_addr}, {32'h0, M1_ADDR});
        $display("seq lock: flush=%0b addr=%h", mem_flush, mem_addr);

        @(posedge clk); #1; drive_idle();
        m0_flush = 1'b1; mem_accept = 1'b1;
        @(negedge clk);
        chk("hold release no transfer", {62'h0, m0_accept, mem_flush}, 64'h0);
        $display("seq release: a0=%0b flush=%0b", m0_accept, mem_flush);

        @(posedge clk); #1; drive_idle();
        m0_flush = 1'b1; mem_accept = 1'b1;
        @(negedge clk);
        chk("m0 flush forwarded", {61'h0, m0_accept, mem_flush, mem_rd}, 64'h6);
        $display("seq flush: a0=%0b flush=%0b rd=%0b", m0_accept, mem_flush, mem_rd);

        @(posedge clk); #1; drive_idle();
        mem_ack = 1'b1; mem_resp_tag = T0;
        @(negedge clk);
        chk("flush ack to m0", {51'h0, m0_ack, m1_ack, m0_resp_tag},
            {51'h0, 1'b1, 1'b0, T0});
        $display("seq flush ack: k0=%0b k1=%0b tag=%h", m0_ack, m1_ack, m0_resp_tag);

        @(posedge clk); #1; drive_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
